// File: rtl/sa3_pkg.sv
// rtl/sa3_pkg.sv - shared types, sizes and operand-slot packing for the sa3 tile loader
package sa3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam int N_FLT       = 9;
   localparam int N_ACT       = 16;
   localparam int N_RD        = 25;
   localparam int SA3_SEQ_LEN = 17;

   // Slots 0..8 (filter) then 9..24 (activations) sit back to back, so the bit
   // offset of a slot in {act_flat, flt_flat} is simply 8*slot.
   function automatic logic [7:0] slot_lsb(input logic [4:0] slot);
      return {slot, 3'b000};
   endfunction

endpackage

// File: rtl/relu8.sv
// rtl/relu8.sv - 8-bit signed clip to zero, bypassed when EN is 0
module relu8 #(
   parameter int EN = 1
) (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = ((EN != 0) && din[7]) ? 8'h00 : din;

endmodule

// File: rtl/sa3_tile_loader.sv
// rtl/sa3_tile_loader.sv - operand fetch from byte SRAM and result collect for the 3x3 systolic array
module sa3_tile_loader
   import sa3_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int RELU_EN = 1,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_flt,
   input  logic [ADDR_W-1:0] base_act,
   output logic              busy,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [71:0]       flt_flat,
   output logic [127:0]      act_flat,
   output logic              sa_active,
   input  logic              sa_done,
   input  logic [7:0]        sa_c11,
   input  logic [7:0]        sa_c12,
   input  logic [7:0]        sa_c21,
   input  logic [7:0]        sa_c22,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              err
);

   localparam int RUN_W = $clog2(TIMEOUT + 1);

   state_t              state, state_nxt;
   logic [4:0]          cnt, cnt_nxt;
   logic [RUN_W-1:0]    run_cnt;
   logic [ADDR_W-1:0]   base_flt_q, base_act_q;
   logic [8*N_RD-1:0]   slots;
   logic [7:0]          r11, r12, r21, r22;
   logic                load_last, run_timeout;

   relu8 #(.EN(RELU_EN)) u_relu11 (.din(sa_c11), .dout(r11));
   relu8 #(.EN(RELU_EN)) u_relu12 (.din(sa_c12), .dout(r12));
   relu8 #(.EN(RELU_EN)) u_relu21 (.din(sa_c21), .dout(r21));
   relu8 #(.EN(RELU_EN)) u_relu22 (.din(sa_c22), .dout(r22));

   assign busy        = (state != ST_IDLE);
   assign flt_flat    = slots[8*N_FLT-1:0];
   assign act_flat    = slots[8*N_RD-1:8*N_FLT];
   assign cnt_nxt     = cnt + 5'd1;
   assign load_last   = (cnt == 5'(N_RD));
   assign run_timeout = (run_cnt == RUN_W'(TIMEOUT - 1));

   function automatic logic [ADDR_W-1:0] rd_addr(input logic [4:0] n,
                                                 input logic [ADDR_W-1:0] bf,
                                                 input logic [ADDR_W-1:0] ba);
      if (n < 5'(N_FLT))
         return bf + ADDR_W'(n);
      else
         return ba + ADDR_W'(n - 5'(N_FLT));
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: if (load_last) state_nxt = ST_RUN;
         ST_RUN: begin
            if (sa_done)
               state_nxt = ST_HOLD;
            else if (run_timeout)
               state_nxt = ST_IDLE;
         end
         ST_HOLD: if (out_valid && out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         run_cnt    <= '0;
         base_flt_q <= '0;
         base_act_q <= '0;
         slots      <= '0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         sa_active  <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_flt_q <= base_flt;
                  base_act_q <= base_act;
                  err        <= 1'b0;
                  cnt        <= '0;
                  mem_rd_en  <= 1'b1;
                  mem_addr   <= base_flt;
               end
            end
            ST_LOAD: begin
               // SRAM data lags the strobe by one cycle, so each cycle stores the previous read.
               if (cnt != 5'd0)
                  slots[slot_lsb(cnt - 5'd1) +: 8] <= mem_rdata;
               cnt <= cnt_nxt;
               if (cnt_nxt < 5'(N_RD)) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= rd_addr(cnt_nxt, base_flt_q, base_act_q);
               end else begin
                  mem_rd_en <= 1'b0;
               end
               if (load_last) begin
                  sa_active <= 1'b1;
                  run_cnt   <= '0;
               end
            end
            ST_RUN: begin
               if (sa_done) begin
                  sa_active <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= {r22, r21, r12, r11};
               end else if (run_timeout) begin
                  sa_active <= 1'b0;
                  err       <= 1'b1;
               end else begin
                  run_cnt <= run_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sa3_tile_loader.md
# sa3_tile_loader

Operand-fetch and result-collect controller that sits directly upstream of the 3×3 systolic array (4×4 input tile, 3×3 filter, 2×2 output). On `start` it reads 9 filter bytes and 16 activation bytes from a byte-wide synchronous SRAM and holds them stable on flat operand buses. It then drives the array's `active` input until the array signals done, captures and optionally ReLU-clips the four results, and presents them on a valid/ready port.

## Interface
- `ADDR_W`, 10, SRAM byte-address width.
- `RELU_EN`, 1, 1 = results treated as signed 8-bit and negatives forced to 0; 0 = pass-through.
- `TIMEOUT`, 32, max RUN cycles to wait for `sa_done` before error.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle request; ignored unless IDLE.
- `base_flt` in ADDR_W: filter base address, b11..b33 row-major at +0..+8.
- `base_act` in ADDR_W: activation base address, a11..a44 row-major at +0..+15.
- `busy` out 1: high in any state other than IDLE.
- `mem_rd_en` out 1: SRAM read strobe.
- `mem_addr` out ADDR_W: SRAM read address.
- `mem_rdata` in 8: SRAM data, valid exactly 1 cycle after `mem_rd_en`.
- `flt_flat` out 72: b_rc at bits [8*(3*(r-1)+(c-1)) +: 8].
- `act_flat` out 128: a_rc at bits [8*(4*(r-1)+(c-1)) +: 8].
- `sa_active` out 1: to array `active_sa3`.
- `sa_done` in 1: from array `done_sa3`, combinational in its final state.
- `sa_c11`, `sa_c12`, `sa_c21`, `sa_c22` in 8 each: array results.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_data` out 32: {c22, c21, c12, c11}.
- `err` out 1: sticky timeout flag, cleared by next accepted `start`.

## Operation
- States: IDLE, LOAD, RUN, HOLD.
- IDLE: `start`=1 latches bases, clears `err` and `cnt`, then goes to LOAD.
- LOAD: `cnt` runs 0..25.
  - For `cnt` < 25: `mem_rd_en`=1.
  - `mem_addr` = `base_flt`+`cnt` for `cnt` 0..8, and `base_act`+(`cnt`-9) for 9..24.
  - Address addition wraps modulo 2^ADDR_W.
  - For `cnt` ≥ 1: `mem_rdata` is written into slot `cnt`-1. Slots 0..8 are b11..b33; slots 9..24 are a11..a44.
  - At `cnt`=25 the last byte is written and the state goes to RUN.
- RUN: `sa_active`=1 and the RUN counter increments.
  - `sa_done`=1: capture results (ReLU applied per `RELU_EN`), drop `sa_active`, go to HOLD.
  - Counter reaches `TIMEOUT` without `sa_done`: set `err`, drop `sa_active`, go to IDLE with `out_valid` not raised.
- HOLD: `out_valid`=1 with `out_data` stable. A cycle with `out_valid`&&`out_ready` returns to IDLE.
- `start` is ignored in LOAD, RUN and HOLD. It is honored in IDLE even in the cycle right after a handshake.
- `flt_flat` and `act_flat` are only rewritten during LOAD and hold their values otherwise, including through HOLD and IDLE.
- ReLU: if bit 7 is set, output 0x00; else pass the value.

## Timing
- Reset values: `busy`=0, `mem_rd_en`=0, `mem_addr`=0, `flt_flat`=0, `act_flat`=0, `sa_active`=0, `out_valid`=0, `out_data`=0, `err`=0. State is IDLE.
- All outputs are registered except `busy` (decoded from state).
- LOAD lasts 26 cycles. `sa_active` rises on the edge after `cnt`=25.
- The array's 17-cycle sequence puts `sa_done` in the 17th RUN cycle. `sa_active` falls and `out_valid` rises on the following edge.
- Start-sample edge to `out_valid` edge: 43 cycles nominal. `sa_active` is high for exactly 17 cycles.
- `sa_active` must stay high through the `sa_done` cycle so the array returns to its first state. It must never fall mid-sequence except on timeout.
- `rst` mid-operation: immediate return to IDLE. All outputs return to reset values, including the operand buses. The array shares `rst`.
- `out_ready` asserted before `out_valid` has no effect.

## Structure
- Shared package `sa3_pkg` holds:
  - the state enum;
  - `N_FLT`=9, `N_ACT`=16, `N_RD`=25;
  - `SA3_SEQ_LEN`=17;
  - the slot-to-bus packing function.
- One natural sub-module: `relu8`, an 8-bit combinational clip, instantiated four times.
- Everything else is one FSM plus the counter in `sa3_tile_loader`.

## Test plan
- Basic load: SRAM byte at address A holds A[7:0]; `base_flt`=0x000, `base_act`=0x010, `start` pulse. Required: 25 reads at 0x000..0x008 then 0x010..0x01F; `flt_flat` bytes 0x00..0x08 and `act_flat` bytes 0x10..0x1F in slot order.
- Full run against the array: identity-center filter (b22=1, others 0), a_rc = 4r+c. Required: `out_data`={a33,a32,a23,a22}={0x0F,0x0E,0x0B,0x0A}; `out_valid` 43 cycles after start; `sa_active` high for 17 cycles.
- ReLU: stub array returns c11=0x85, c12=0x7F, c21=0x80, c22=0x01. `RELU_EN`=1 gives 0x01007F00; `RELU_EN`=0 gives 0x01807F85.
- Backpressure and start handling: hold `out_ready`=0 for 10 cycles with `start` pulsed in HOLD. Required: `out_data` stable, `start` ignored, return to IDLE the cycle after `out_ready`=1.
- Timeout and wrap: stub array never asserts done, `base_act`=0x3F8. Required: addresses wrap 0x3FF→0x000; `err`=1 after 32 RUN cycles; `out_valid` stays 0; next `start` clears `err`.
- Reset mid-RUN: assert `rst` in RUN cycle 5. Required: all outputs 0 asynchronously; a fresh `start` completes normally.
